// File: rtl/mult6_pkg.sv
// Shared types and constants for the two-requester 6x6 multiplier arbiter.
package mult6_pkg;

  localparam int OP_W           = 6;
  localparam int PROD_W         = 12;
  localparam int N_REQ          = 2;
  localparam int CNT_W          = 8;
  localparam int MUL_CYCLES_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; the last_grant history moves only when a grant is taken.
module rr_arb2
  import mult6_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             update,
  output logic [N_REQ-1:0] grant
);

  logic last_grant_q;
  logic last_grant_d;

  // A tie goes to whoever was not served last; a lone request always wins.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (update) begin
      last_grant_d = grant[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mult6_arbiter.sv
// Shares one signed 6x6 multiplier between two requesters; the multiplier has no
// done flag, so the result is captured a fixed MUL_CYCLES after the start pulse.
module mult6_arbiter
  import mult6_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_valid,
  output logic [N_REQ-1:0]  req_ready,
  input  logic [OP_W-1:0]   a0,
  input  logic [OP_W-1:0]   b0,
  input  logic [OP_W-1:0]   a1,
  input  logic [OP_W-1:0]   b1,
  output logic [N_REQ-1:0]  resp_valid,
  input  logic [N_REQ-1:0]  resp_ready,
  output logic [PROD_W-1:0] resp_c,
  output logic              resp_neg,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  output logic              mul_start,
  input  logic [PROD_W-1:0] mul_c,
  input  logic              mul_neg,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               id_q;
  logic [OP_W-1:0]    a_q, b_q;
  logic [OP_W-1:0]    a_d, b_d;
  logic [PROD_W-1:0]  c_q;
  logic               neg_q;
  logic               mul_start_q;
  logic               busy_q;
  logic [N_REQ-1:0]   resp_valid_q;
  logic [N_REQ-1:0]   grant;
  logic               in_idle;
  logic               accept;

  assign in_idle = (state_q == IDLE);
  assign accept  = in_idle && (|req_valid);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .update (accept),
    .grant  (grant)
  );

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = in_idle & grant[gi];
    end
  endgenerate

  assign a_d = grant[1] ? a1 : a0;
  assign b_d = grant[1] ? b1 : b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      neg_q        <= 1'b0;
      mul_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= grant[1];
            mul_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= LAUNCH;
          end
        end
        LAUNCH: begin
          mul_start_q <= 1'b0;
          cnt_q       <= CNT_LOAD;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            c_q          <= mul_c;
            neg_q        <= mul_neg;
            resp_valid_q <= {id_q, ~id_q};
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          // Only the granted requester's ready can retire the result.
          if (resp_ready[id_q]) begin
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_c     = c_q;
  assign resp_neg   = neg_q;
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign mul_start  = mul_start_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mult6_arbiter.sv
// Directed bench: a transaction table on the default build plus hand-written
// stall, reset-abort and MUL_CYCLES=1 sequences.
module tb_mult6_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [1:0]  req_valid = '0, req_ready, resp_valid, resp_ready = '0;
  logic [5:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0, mul_a, mul_b;
  logic [11:0] resp_c, mul_c;
  logic        resp_neg, mul_start, mul_neg, busy;

  logic [1:0]  u1_req_valid = '0, u1_req_ready, u1_resp_valid, u1_resp_ready = '0;
  logic [5:0]  u1_a0 = '0, u1_b0 = '0, u1_mul_a, u1_mul_b;
  logic [11:0] u1_resp_c, u1_mul_c;
  logic        u1_resp_neg, u1_mul_start, u1_mul_neg, u1_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared multiplier.
  function automatic logic [11:0] mul(input logic [5:0] a, input logic [5:0] b);
    logic signed [11:0] x, y;
    x = {{6{a[5]}}, a};
    y = {{6{b[5]}}, b};
    return x * y;
  endfunction

  assign mul_c      = mul(mul_a, mul_b);
  assign mul_neg    = mul_c[11];
  assign u1_mul_c   = mul(u1_mul_a, u1_mul_b);
  assign u1_mul_neg = u1_mul_c[11];

  mult6_arbiter #(.MUL_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_c(resp_c), .resp_neg(resp_neg),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_c(mul_c), .mul_neg(mul_neg),
    .busy(busy)
  );

  mult6_arbiter #(.MUL_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(u1_req_valid), .req_ready(u1_req_ready),
    .a0(u1_a0), .b0(u1_b0), .a1(6'd0), .b1(6'd0),
    .resp_valid(u1_resp_valid), .resp_ready(u1_resp_ready), .resp_c(u1_resp_c),
    .resp_neg(u1_resp_neg), .mul_a(u1_mul_a), .mul_b(u1_mul_b), .mul_start(u1_mul_start),
    .mul_c(u1_mul_c), .mul_neg(u1_mul_neg), .busy(u1_busy)
  );

  typedef struct {
    logic [1:0]  rv;
    logic [5:0]  a0, b0, a1, b1;
    logic [1:0]  gnt;
    logic [11:0] c;
    logic        neg;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one request at a negedge in IDLE and follow it through to retirement.
  task automatic run_txn(input vec_t v, input string tag);
    int lat;
    a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1;
    req_valid = v.rv;
    #1;
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(v.gnt));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_ready_launch"}, 32'(req_ready), 32'd0);
    req_valid = '0;
    chk({tag, "_mul_start"}, 32'(mul_start), 32'd1);
    chk({tag, "_mul_a"}, 32'(mul_a), 32'(v.gnt[1] ? v.a1 : v.a0));
    chk({tag, "_mul_b"}, 32'(mul_b), 32'(v.gnt[1] ? v.b1 : v.b0));
    lat = 1;
    while (resp_valid == 2'b00 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 2) chk({tag, "_start_pulse_end"}, 32'(mul_start), 32'd0);
    end
    chk({tag, "_latency"}, 32'(lat), 32'd10);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'(v.gnt));
    chk({tag, "_resp_c"}, 32'(resp_c), 32'(v.c));
    chk({tag, "_resp_neg"}, 32'(resp_neg), 32'(v.neg));
    resp_ready = v.gnt;
    @(negedge clk);
    resp_ready = '0;
    chk({tag, "_retired"}, 32'({busy, resp_valid}), 32'd0);
    $display("[TB] %s: rv=%b grant=%b c=%h neg=%b lat=%0d", tag, v.rv, v.gnt, resp_c, resp_neg, lat);
  endtask

  initial begin
    vec_t v;
    int lat;

    tbl[0] = '{2'b11, 6'h20, 6'h20, 6'd7,  6'd9,  2'b01, 12'h400, 1'b0};
    tbl[1] = '{2'b10, 6'h20, 6'h20, 6'd7,  6'd9,  2'b10, 12'h03F, 1'b0};
    tbl[2] = '{2'b01, 6'd5,  6'h3D, 6'd0,  6'd0,  2'b01, 12'hFF1, 1'b1};
    tbl[3] = '{2'b10, 6'd0,  6'd0,  6'h3C, 6'd6,  2'b10, 12'hFE8, 1'b1};
    tbl[4] = '{2'b10, 6'd0,  6'd0,  6'h1F, 6'h1F, 2'b10, 12'h3C1, 1'b0};
    tbl[5] = '{2'b11, 6'h3F, 6'd1,  6'd2,  6'd3,  2'b01, 12'hFFF, 1'b1};
    tbl[6] = '{2'b11, 6'h3F, 6'd1,  6'd2,  6'd3,  2'b10, 12'h006, 1'b0};
    tbl[7] = '{2'b01, 6'd0,  6'h3B, 6'd0,  6'd0,  2'b01, 12'h000, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({req_ready, resp_valid, resp_c, resp_neg, mul_a, mul_b, mul_start, busy}), 32'd0);
    chk("reset_outputs_u1", 32'({u1_resp_valid, u1_resp_c, u1_mul_start, u1_busy}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Result held across a 5-cycle resp_ready stall; other traffic must wait.
    a0 = 6'd3; b0 = 6'h39; req_valid = 2'b01;
    @(posedge clk); @(negedge clk);
    req_valid = '0; a0 = '0; b0 = '0;
    lat = 1;
    while (resp_valid == 2'b00 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("stall_latency", 32'(lat), 32'd10);
    a1 = 6'd2; b1 = 6'd2; req_valid = 2'b10; resp_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_resp", 32'({resp_valid, resp_c, resp_neg}), 32'({2'b01, 12'hFEB, 1'b1}));
      chk("stall_ops", 32'({mul_a, mul_b}), 32'({6'd3, 6'h39}));
      @(negedge clk);
    end
    req_valid = '0; resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = '0;
    chk("stall_exit", 32'({busy, resp_valid}), 32'd0);
    $display("[TB] stall: resp held 5 cycles, then retired");

    // Abort during WAIT; previous grant was 0, so a tie afterwards checks last_grant reset.
    a0 = 6'd4; b0 = 6'd4; req_valid = 2'b01;
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", 32'({req_ready, resp_valid, resp_c, resp_neg, mul_a, mul_b, mul_start, busy}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("rst_no_reissue", 32'({busy, resp_valid}), 32'd0);
    $display("[TB] reset during WAIT: outputs cleared, no result reissued");
    v = '{2'b11, 6'h38, 6'd4, 6'd1, 6'd1, 2'b01, 12'hFE0, 1'b1};
    run_txn(v, "post_rst");

    // MUL_CYCLES=1 build.
    u1_a0 = 6'd1; u1_b0 = 6'd1; u1_req_valid = 2'b01;
    #1;
    chk("u1_req_ready", 32'(u1_req_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    u1_req_valid = '0;
    chk("u1_mul_start", 32'(u1_mul_start), 32'd1);
    lat = 1;
    while (u1_resp_valid == 2'b00 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("u1_latency", 32'(lat), 32'd3);
    chk("u1_resp", 32'({u1_resp_valid, u1_resp_c, u1_resp_neg}), 32'({2'b01, 12'h001, 1'b0}));
    u1_resp_ready = 2'b01;
    @(negedge clk);
    u1_resp_ready = '0;
    chk("u1_retired", 32'({u1_busy, u1_resp_valid}), 32'd0);
    $display("[TB] u1: 1x1 c=%h lat=%0d", u1_resp_c, lat);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
